// File: rtl/ltl_nfa_pkg.sv
// Shared types for the LTL NFA engine: config selectors, start types,
// FSM encoding and the default report-entry layout.
package ltl_nfa_pkg;

    typedef enum logic [1:0] {
        CFG_MATCH  = 2'd0,
        CFG_EDGE   = 2'd1,
        CFG_START  = 2'd2,
        CFG_REPORT = 2'd3
    } cfg_sel_e;

    // Code 3 is reserved and behaves exactly like ST_NONE.
    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SOD  = 2'd1,
        ST_ALL  = 2'd2,
        ST_RSVD = 2'd3
    } start_type_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } fsm_e;

    localparam int DEF_NUM_STATES = 16;
    localparam int DEF_POS_W      = 32;

    // Layout of one report entry at the default sizes; the FIFO stores
    // entries packed the same way, {vec, pos}.
    typedef struct packed {
        logic [DEF_NUM_STATES-1:0] vec;
        logic [DEF_POS_W-1:0]      pos;
    } rpt_entry_t;

endpackage

// File: rtl/ltl_rpt_fifo.sv
// Synchronous report FIFO with full/empty flags. DEPTH must be a power of
// two so the pointers wrap naturally. A push on a full FIFO is taken only
// when a pop happens in the same cycle.
module ltl_rpt_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == (AW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer, occupancy and storage update for one push/pop pair.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // State registers; reset empties the FIFO and clears its storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ltl_nfa_engine.sv
// Runtime-programmable homogeneous NFA engine. Each state owns a symbol
// match column, an in-edge mask and a start type; the active vector
// advances once per accepted symbol and reporting states are queued with
// the 0-based position of the symbol that fired them.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Symbols use sym_valid/sym_ready, reports use
// rpt_valid/rpt_ready; rpt_vec/rpt_pos hold while rpt_valid && !rpt_ready.
module ltl_nfa_engine
    import ltl_nfa_pkg::*;
#(
    parameter int NUM_STATES = 16,
    parameter int SYM_W      = 8,
    parameter int RPT_DEPTH  = 8,
    parameter int POS_W      = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [1:0]                    cfg_sel,
    input  logic [$clog2(NUM_STATES)-1:0] cfg_state,
    input  logic [SYM_W-1:0]              cfg_idx,
    input  logic [NUM_STATES-1:0]         cfg_wdata,
    output logic                          cfg_err,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          sym_valid,
    input  logic [SYM_W-1:0]              sym,
    output logic                          sym_ready,
    output logic                          rpt_valid,
    input  logic                          rpt_ready,
    output logic [NUM_STATES-1:0]         rpt_vec,
    output logic [POS_W-1:0]              rpt_pos,
    output logic                          busy,
    output logic                          active_any
);
    localparam int NSYM  = 1 << SYM_W;
    localparam int ENT_W = NUM_STATES + POS_W;

    // Match table is stored symbol-major so one read yields the whole
    // per-state match vector for the incoming symbol.
    logic [NUM_STATES-1:0] match_q [NSYM];
    logic [NUM_STATES-1:0] match_d [NSYM];
    logic [NUM_STATES-1:0] in_edge_q [NUM_STATES];
    logic [NUM_STATES-1:0] in_edge_d [NUM_STATES];
    start_type_e           start_type_q [NUM_STATES];
    start_type_e           start_type_d [NUM_STATES];
    logic [NUM_STATES-1:0] report_mask_q, report_mask_d;
    logic [NUM_STATES-1:0] active_q, active_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic                  cfg_err_q, cfg_err_d;
    fsm_e                  fsm_q, fsm_d;

    logic [NUM_STATES-1:0] enable, next_vec, rpt_hit;
    logic                  sym_acc, push, fifo_full, fifo_empty;
    logic [ENT_W-1:0]      pop_data;

    // Config writes land only in IDLE; anything else raises cfg_err next cycle.
    always_comb begin
        match_d       = match_q;
        in_edge_d     = in_edge_q;
        start_type_d  = start_type_q;
        report_mask_d = report_mask_q;
        cfg_err_d     = 1'b0;
        if (cfg_we) begin
            if (fsm_q == IDLE) begin
                case (cfg_sel_e'(cfg_sel))
                    CFG_MATCH:  match_d[cfg_idx][cfg_state] = cfg_wdata[0];
                    CFG_EDGE:   in_edge_d[cfg_state]        = cfg_wdata;
                    CFG_START:  start_type_d[cfg_state]     = start_type_e'(cfg_wdata[1:0]);
                    default:    report_mask_d               = cfg_wdata;
                endcase
            end else begin
                cfg_err_d = 1'b1;
            end
        end
    end

    // Per-state enable and next active vector for the symbol on the bus.
    always_comb begin
        enable = '0;
        for (int i = 0; i < NUM_STATES; i++) begin
            enable[i] = (|(active_q & in_edge_q[i]))
                      | (start_type_q[i] == ST_SOD && fsm_q == FIRST)
                      | (start_type_q[i] == ST_ALL);
        end
        next_vec = enable & match_q[sym];
        rpt_hit  = next_vec & report_mask_q;
    end

    // Run-control FSM: arming, symbol acceptance, abort.
    always_comb begin
        fsm_d     = fsm_q;
        active_d  = active_q;
        pos_d     = pos_q;
        push      = 1'b0;
        sym_ready = (fsm_q == FIRST || fsm_q == RUN) && !fifo_full && !stop;
        sym_acc   = sym_valid && sym_ready;
        case (fsm_q)
            IDLE: begin
                if (start && !stop) begin
                    fsm_d    = FIRST;
                    active_d = '0;
                    pos_d    = '0;
                end
            end
            FIRST, RUN: begin
                if (stop) begin
                    fsm_d    = IDLE;
                    active_d = '0;
                end else if (sym_acc) begin
                    fsm_d    = RUN;
                    active_d = next_vec;
                    pos_d    = pos_q + POS_W'(1);
                    push     = |rpt_hit;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // Configuration and run-state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NSYM; s++) match_q[s] <= '0;
            for (int i = 0; i < NUM_STATES; i++) begin
                in_edge_q[i]    <= '0;
                start_type_q[i] <= ST_NONE;
            end
            report_mask_q <= '0;
            active_q      <= '0;
            pos_q         <= '0;
            cfg_err_q     <= 1'b0;
            fsm_q         <= IDLE;
        end else begin
            match_q       <= match_d;
            in_edge_q     <= in_edge_d;
            start_type_q  <= start_type_d;
            report_mask_q <= report_mask_d;
            active_q      <= active_d;
            pos_q         <= pos_d;
            cfg_err_q     <= cfg_err_d;
            fsm_q         <= fsm_d;
        end
    end

    ltl_rpt_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (RPT_DEPTH)
    ) u_rpt_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({rpt_hit, pos_q}),
        .pop       (rpt_valid && rpt_ready),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign rpt_valid  = !fifo_empty;
    assign rpt_vec    = pop_data[ENT_W-1:POS_W];
    assign rpt_pos    = pop_data[POS_W-1:0];
    assign cfg_err    = cfg_err_q;
    assign busy       = (fsm_q != IDLE);
    assign active_any = |active_q;

endmodule

// File: tb/tb_ltl_nfa_engine.sv
// Directed bench for ltl_nfa_engine (report FIFO depth 4). Reports are
// captured into got_q as they are handed over and compared with exp_q.
module tb_ltl_nfa_engine;
    localparam int N     = 16;
    localparam int SW    = 8;
    localparam int DEPTH = 4;
    localparam int PW    = 32;
    localparam int EW    = N + PW;

    logic          clk = 1'b0;
    logic          reset, cfg_we, start, stop, sym_valid, rpt_ready;
    logic [1:0]    cfg_sel;
    logic [3:0]    cfg_state;
    logic [SW-1:0] cfg_idx, sym;
    logic [N-1:0]  cfg_wdata, rpt_vec;
    logic [PW-1:0] rpt_pos;
    logic          cfg_err, sym_ready, rpt_valid, busy, active_any;

    int n_checks = 0;
    int n_fails  = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] got_q[$];

    ltl_nfa_engine #(.NUM_STATES(N), .SYM_W(SW), .RPT_DEPTH(DEPTH), .POS_W(PW)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_state(cfg_state),
        .cfg_idx(cfg_idx), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .start(start), .stop(stop),
        .sym_valid(sym_valid), .sym(sym), .sym_ready(sym_ready), .rpt_valid(rpt_valid),
        .rpt_ready(rpt_ready), .rpt_vec(rpt_vec), .rpt_pos(rpt_pos), .busy(busy),
        .active_any(active_any)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        #1;
        if (!reset && rpt_valid && rpt_ready) got_q.push_back({rpt_vec, rpt_pos});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        reset = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_state = '0; cfg_idx = '0;
        cfg_wdata = '0; start = 1'b0; stop = 1'b0; sym_valid = 1'b0; sym = '0;
        rpt_ready = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [3:0] st,
                             input logic [SW-1:0] idx, input logic [N-1:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_state = st; cfg_idx = idx; cfg_wdata = data;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic arm();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic send_sym(input logic [SW-1:0] s);
        int waited = 0;
        sym_valid = 1'b1; sym = s;
        #1;
        while (!sym_ready && waited < 50) begin
            cyc();
            waited++;
        end
        if (waited >= 50) begin
            n_checks++; n_fails++;
            $display("FAIL sym_accept_timeout: sym_ready=%b after %0d cycles, expected 1", sym_ready, waited);
        end else begin
            cyc();
        end
        sym_valid = 1'b0;
    endtask

    // Two-state chain: s0 start-of-data on 0x41, s1 fed by s0 on 0x42, s1 reports.
    task automatic cfg_chain();
        cfg_write(2'd0, 4'd0, 8'h41, 16'h0001);
        cfg_write(2'd0, 4'd1, 8'h42, 16'h0001);
        cfg_write(2'd1, 4'd1, 8'h00, 16'h0001);
        cfg_write(2'd2, 4'd0, 8'h00, 16'h0001);
        cfg_write(2'd3, 4'd0, 8'h00, 16'h0002);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_checks++; if (sym_ready !== 1'b0) begin n_fails++; $display("FAIL reset_sym_ready: got %b expected 0", sym_ready); end
        n_checks++; if (rpt_valid !== 1'b0) begin n_fails++; $display("FAIL reset_rpt_valid: got %b expected 0", rpt_valid); end
        n_checks++; if (cfg_err !== 1'b0) begin n_fails++; $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (active_any !== 1'b0) begin n_fails++; $display("FAIL reset_active_any: got %b expected 0", active_any); end
    endtask

    task automatic test_chain();
        logic [EW-1:0] e, g;
        do_reset();
        cfg_chain();
        arm();
        n_checks++; if (busy !== 1'b1) begin n_fails++; $display("FAIL chain_busy: got %b expected 1", busy); end
        exp_q.push_back({16'h0002, 32'd1});
        send_sym(8'h41);
        n_checks++; if (active_any !== 1'b1) begin n_fails++; $display("FAIL chain_active: got %b expected 1", active_any); end
        n_checks++; if (rpt_valid !== 1'b0) begin n_fails++; $display("FAIL chain_no_rpt_pos0: got %b expected 0", rpt_valid); end
        send_sym(8'h42);
        n_checks++; if (rpt_valid !== 1'b1) begin n_fails++; $display("FAIL chain_rpt_latency: got %b expected 1", rpt_valid); end
        wait_cycles(3);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL chain_count: got %0d entries expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fails++; $display("FAIL chain_entry: got vec=%h pos=%0d expected vec=%h pos=%0d", g[EW-1:PW], g[PW-1:0], e[EW-1:PW], e[PW-1:0]); end
        end
        exp_q.delete(); got_q.delete();
        halt();
    endtask

    task automatic test_all_input();
        logic [EW-1:0] e, g;
        do_reset();
        cfg_write(2'd0, 4'd0, 8'h10, 16'h0001);
        cfg_write(2'd2, 4'd0, 8'h00, 16'h0002);
        cfg_write(2'd3, 4'd0, 8'h00, 16'h0001);
        arm();
        exp_q.push_back({16'h0001, 32'd0});
        exp_q.push_back({16'h0001, 32'd2});
        send_sym(8'h10);
        send_sym(8'h00);
        send_sym(8'h10);
        wait_cycles(3);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL allin_count: got %0d entries expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fails++; $display("FAIL allin_entry: got vec=%h pos=%0d expected vec=%h pos=%0d", g[EW-1:PW], g[PW-1:0], e[EW-1:PW], e[PW-1:0]); end
        end
        exp_q.delete(); got_q.delete();
        halt();
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] e, g;
        int acc = 0;
        do_reset();
        for (int s = 0; s < 256; s++) cfg_write(2'd0, 4'd0, SW'(s), 16'h0001);
        cfg_write(2'd1, 4'd0, 8'h00, 16'h0001);
        cfg_write(2'd2, 4'd0, 8'h00, 16'h0001);
        cfg_write(2'd3, 4'd0, 8'h00, 16'h0001);
        rpt_ready = 1'b0;
        arm();
        for (int p = 0; p < 6; p++) exp_q.push_back({16'h0001, PW'(p)});
        sym_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            sym = SW'(c + 8'h30);
            if (sym_ready) acc++;
            cyc();
        end
        sym_valid = 1'b0;
        n_checks++; if (acc != DEPTH) begin n_fails++; $display("FAIL bp_accepted: got %0d expected %0d", acc, DEPTH); end
        n_checks++; if (sym_ready !== 1'b0) begin n_fails++; $display("FAIL bp_sym_ready_full: got %b expected 0", sym_ready); end
        n_checks++; if (rpt_pos !== 32'd0) begin n_fails++; $display("FAIL bp_head_held: got pos %0d expected 0", rpt_pos); end
        rpt_ready = 1'b1;
        send_sym(8'h55);
        send_sym(8'haa);
        wait_cycles(10);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL bp_count: got %0d entries expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fails++; $display("FAIL bp_entry: got vec=%h pos=%0d expected vec=%h pos=%0d", g[EW-1:PW], g[PW-1:0], e[EW-1:PW], e[PW-1:0]); end
        end
        exp_q.delete(); got_q.delete();
        halt();
    endtask

    task automatic test_cfg_err();
        logic [EW-1:0] e, g;
        do_reset();
        cfg_write(2'd0, 4'd0, 8'h20, 16'h0001);
        cfg_write(2'd2, 4'd0, 8'h00, 16'h0002);
        cfg_write(2'd3, 4'd0, 8'h00, 16'h0001);
        n_checks++; if (cfg_err !== 1'b0) begin n_fails++; $display("FAIL cfgerr_idle_write: got %b expected 0", cfg_err); end
        arm();
        exp_q.push_back({16'h0001, 32'd0});
        exp_q.push_back({16'h0001, 32'd2});
        send_sym(8'h20);
        cfg_write(2'd0, 4'd0, 8'h21, 16'h0001);
        n_checks++; if (cfg_err !== 1'b1) begin n_fails++; $display("FAIL cfgerr_pulse: got %b expected 1", cfg_err); end
        cyc();
        n_checks++; if (cfg_err !== 1'b0) begin n_fails++; $display("FAIL cfgerr_one_cycle: got %b expected 0", cfg_err); end
        send_sym(8'h21);
        send_sym(8'h20);
        wait_cycles(3);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL cfgerr_count: got %0d entries expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fails++; $display("FAIL cfgerr_entry: got vec=%h pos=%0d expected vec=%h pos=%0d", g[EW-1:PW], g[PW-1:0], e[EW-1:PW], e[PW-1:0]); end
        end
        exp_q.delete(); got_q.delete();
        halt();
    endtask

    task automatic test_stop_restart();
        logic [EW-1:0] e, g;
        do_reset();
        cfg_chain();
        arm();
        send_sym(8'h41);
        stop = 1'b1;
        #1;
        n_checks++; if (sym_ready !== 1'b0) begin n_fails++; $display("FAIL stop_sym_ready: got %b expected 0", sym_ready); end
        cyc();
        stop = 1'b0;
        n_checks++; if (active_any !== 1'b0) begin n_fails++; $display("FAIL stop_active_any: got %b expected 0", active_any); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL stop_busy: got %b expected 0", busy); end
        arm();
        exp_q.push_back({16'h0002, 32'd1});
        send_sym(8'h41);
        n_checks++; if (active_any !== 1'b1) begin n_fails++; $display("FAIL restart_reseed: got %b expected 1", active_any); end
        send_sym(8'h42);
        wait_cycles(3);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fails++; $display("FAIL restart_count: got %0d entries expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fails++; $display("FAIL restart_entry: got vec=%h pos=%0d expected vec=%h pos=%0d", g[EW-1:PW], g[PW-1:0], e[EW-1:PW], e[PW-1:0]); end
        end
        exp_q.delete(); got_q.delete();
        halt();
    endtask

    task automatic test_reset_pending();
        do_reset();
        cfg_write(2'd0, 4'd0, 8'h33, 16'h0001);
        cfg_write(2'd2, 4'd0, 8'h00, 16'h0002);
        cfg_write(2'd3, 4'd0, 8'h00, 16'h0001);
        rpt_ready = 1'b0;
        arm();
        send_sym(8'h33);
        send_sym(8'h33);
        send_sym(8'h33);
        n_checks++; if (rpt_valid !== 1'b1) begin n_fails++; $display("FAIL rstpend_pending: got %b expected 1", rpt_valid); end
        reset = 1'b1;
        cyc();
        n_checks++; if (rpt_valid !== 1'b0) begin n_fails++; $display("FAIL rstpend_rpt_valid: got %b expected 0", rpt_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fails++; $display("FAIL rstpend_busy: got %b expected 0", busy); end
        reset = 1'b0;
        rpt_ready = 1'b1;
        exp_q.delete(); got_q.delete();
        arm();
        send_sym(8'h33);
        send_sym(8'h33);
        send_sym(8'h33);
        n_checks++; if (active_any !== 1'b0) begin n_fails++; $display("FAIL rstpend_cfg_cleared: active_any got %b expected 0", active_any); end
        wait_cycles(3);
        n_checks++; if (got_q.size() != 0) begin n_fails++; $display("FAIL rstpend_no_reports: got %0d entries expected 0", got_q.size()); end
        got_q.delete();
        halt();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_chain();
        test_all_input();
        test_backpressure();
        test_cfg_err();
        test_stop_restart();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ltl_nfa_engine.md
Name: ltl_nfa_engine

Overview:
- Runtime-programmable homogeneous NFA engine for the LTL runtime-monitor clusters.
- Replaces per-property, hard-generated automata with one parametrised block:
  - per-state symbol match tables, in-edge masks, start types and report mask are loaded through a config port;
  - symbols stream in with a valid/ready handshake;
  - report events leave through a buffered valid/ready report stream tagged with symbol position.

Parameters:
- NUM_STATES, 16, number of STEs (N)
- SYM_W, 8, symbol width; each match table holds 2^SYM_W entries
- RPT_DEPTH, 8, report FIFO depth (power of two, >=2)
- POS_W, 32, symbol position counter width

Ports:
- clk  in  1  clock
- reset  in  1  sync active-high reset
- cfg_we  in  1  config write strobe
- cfg_sel  in  2  0=MATCH, 1=EDGE, 2=START, 3=REPORT
- cfg_state  in  clog2(N)  target state index
- cfg_idx  in  SYM_W  symbol index (MATCH only)
- cfg_wdata  in  N  write data
- cfg_err  out  1  one-cycle pulse when a write is rejected
- start  in  1  arm engine
- stop  in  1  abort run, return to IDLE
- sym_valid  in  1  symbol valid
- sym  in  SYM_W  input symbol
- sym_ready  out  1  engine accepts symbol
- rpt_valid  out  1  report entry available
- rpt_ready  in  1  consumer accepts report
- rpt_vec  out  N  active report states for the entry
- rpt_pos  out  POS_W  0-based symbol index that caused the report
- busy  out  1  FSM not in IDLE
- active_any  out  1  OR of active-state vector

Behaviour:
- Reset (sync): FSM=IDLE; all config cleared to 0; active vector=0; position=0; FIFO emptied.
- Reset values: sym_ready=0, rpt_valid=0, cfg_err=0, busy=0, active_any=0.
- Config is accepted only in IDLE:
  - MATCH: match[cfg_state][cfg_idx] <= cfg_wdata[0].
  - EDGE: in_edge[cfg_state] <= cfg_wdata; bit j set means edge j->cfg_state; bit cfg_state set means self-loop.
  - START: start_type[cfg_state] <= cfg_wdata[1:0]; 0=none, 1=start-of-data, 2=all-input, 3 treated as none.
  - REPORT: report_mask <= cfg_wdata; cfg_state ignored.
- cfg_we outside IDLE: write dropped; cfg_err high the next cycle for one cycle.
- FSM states:
  - IDLE: on start -> FIRST; clears active vector and position.
  - FIRST: on accepted symbol -> RUN; on stop -> IDLE.
  - RUN: on stop -> IDLE; clears active vector, FIFO contents kept.
- Priority: stop overrides start. cfg_we and start in the same IDLE cycle: the write applies and the start takes effect.
- sym_ready = (FSM in FIRST or RUN) && FIFO not full && !stop. A symbol is accepted when sym_valid && sym_ready.
- Next-state function, applied per state i on an accepted symbol:
  - enable_i = |(active & in_edge[i]) | (start_type[i]==1 && FSM==FIRST) | (start_type[i]==2)
  - next_i = enable_i & match[i][sym]
  - Active vector updates at the accepting edge; no update without acceptance.
- Reporting:
  - Let r = next & report_mask. If r != 0, push {r, pos} into the FIFO at the same edge.
  - rpt_valid is high the following cycle: 1-cycle latency from acceptance.
  - pos increments per accepted symbol and wraps modulo 2^POS_W.
- FIFO:
  - Pop when rpt_valid && rpt_ready.
  - Push and pop in the same cycle on a full FIFO is legal.
  - Backpressure via sym_ready guarantees no overflow; report entries are never lost.
- rpt_vec and rpt_pos are held stable while rpt_valid && !rpt_ready.
- active_any reflects the registered active vector.

Decomposition:
- Package ltl_nfa_pkg holds:
  - cfg_sel_e enum;
  - start_type_e enum;
  - fsm_e {IDLE, FIRST, RUN};
  - report entry struct {vec, pos}.
- Sub-module ltl_rpt_fifo: parametrised synchronous FIFO with full/empty flags, sized RPT_DEPTH by entry width.

Test Plan:
- Two-state chain: state0 start-of-data, match 0x41; state1 edge 0->1, match 0x42; report_mask=0x0002. Stream 0x41,0x42 -> one entry, rpt_vec=0x0002, rpt_pos=1.
- All-input start: state0 type 2, match 0x10, report. Stream 0x10,0x00,0x10 -> entries at pos 0 and 2, nothing at pos 1.
- Backpressure: RPT_DEPTH=4, self-looping report state matching all symbols, rpt_ready=0, offer 6 symbols -> 4 accepted, then sym_ready=0. Raise rpt_ready -> pos 0..5 all delivered in order.
- cfg_we (MATCH) issued during RUN -> cfg_err pulses one cycle; a later match on that entry behaves per the old table.
- stop mid-stream, then start -> active_any=0 after stop; start-of-data states re-seed on the first new symbol; rpt_pos restarts at 0.
- reset asserted with 3 FIFO entries pending -> next cycle rpt_valid=0, busy=0, all config zero; a following run with no config gives no reports.
